// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Decode/execute boundary hazard unit for the 5-stage pipeline. It covers the
//   cases that operand forwarding cannot resolve:
//     * load-use: a lw in D/X whose destination is read by the instruction in F/D
//     * multi-cycle mult/div: it issues the start pulse, then holds the front of
//       the pipeline until the unit returns a result or the watchdog expires
//     * taken branch/jump resolved in X: it squashes F/D and D/X
//   It also keeps a saturating count of the cycles in which the PC and F/D were
//   held.
//
// Ports:
//   clock           pipeline clock
//   reset           asynchronous, active-low reset
//   ir_fd           instruction held in the F/D latch
//   ir_dx           instruction held in the D/X latch
//   branch_taken    X stage resolved a taken branch/jump
//   data_resultRDY  mult/div result valid this cycle
//   data_exception  mult/div exception, qualified by data_resultRDY
//   hold_fd         hold the PC and the F/D latch
//   hold_dx         hold the D/X latch
//   bubble_dx       load a nop into D/X (load-use bubble)
//   flush_fd        load a nop into F/D (branch squash)
//   flush_dx        load a nop into D/X (branch squash)
//   ctrl_MULT       one-cycle multiply start
//   ctrl_DIV        one-cycle divide start
//   md_busy         mult/div sequencer is waiting for a result
//   md_exc          one-cycle pulse: result returned with an exception
//   md_timeout      sticky: an operation was aborted by the watchdog
//   stall_count     saturating count of cycles with hold_fd = 1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ir_fd,
    input  logic [31:0]      ir_dx,
    input  logic             branch_taken,
    input  logic             data_resultRDY,
    input  logic             data_exception,
    output logic             hold_fd,
    output logic             hold_dx,
    output logic             bubble_dx,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic             md_busy,
    output logic             md_exc,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count
);

    // ------------------------------------------------------------------
    // ISA encodings
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // Watchdog counter wide enough to hold MD_TIMEOUT-1.
    localparam int              TO_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // ------------------------------------------------------------------
    // Returns 1 when instruction ir reads register r as a source operand.
    // The sw data register (rd) is deliberately left out: store-data
    // forwarding from M/W already covers a lw feeding a sw's data.
    // ------------------------------------------------------------------
    function automatic logic reads_src(input logic [31:0] ir, input logic [4:0] r);
        logic hit;
        case (ir[31:27])
            OP_RTYPE:              hit = (ir[21:17] == r) || (ir[16:12] == r);
            OP_ADDI, OP_LW, OP_SW: hit = (ir[21:17] == r);
            OP_BNE, OP_BLT:        hit = (ir[26:22] == r) || (ir[21:17] == r);
            OP_JR:                 hit = (ir[26:22] == r);
            OP_J, OP_JAL,
            OP_BEX, OP_SETX:       hit = 1'b0;
            default:               hit = 1'b0;
        endcase
        return hit;
    endfunction

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [4:0] op_dx_s;
    logic [4:0] rd_dx_s;
    logic [4:0] alu_dx_s;
    logic       fd_nop_s;
    logic       dx_nop_s;

    assign op_dx_s  = ir_dx[31:27];
    assign rd_dx_s  = ir_dx[26:22];
    assign alu_dx_s = ir_dx[6:2];
    assign fd_nop_s = (ir_fd == 32'd0);
    assign dx_nop_s = (ir_dx == 32'd0);

    // ------------------------------------------------------------------
    // Load-use detection. A lw into r0 never creates a dependency.
    // ------------------------------------------------------------------
    logic lu_s;

    assign lu_s = (op_dx_s == OP_LW) && (rd_dx_s != 5'd0) &&
                  !fd_nop_s && reads_src(ir_fd, rd_dx_s);

    // ------------------------------------------------------------------
    // Mult/div issue qualification. Issue is also blocked while reset is
    // asserted so that no start pulse can escape before reset release.
    // ------------------------------------------------------------------
    logic md_hit_s;
    logic is_mul_s;

    assign is_mul_s = (alu_dx_s == ALU_MUL);
    assign md_hit_s = reset && !dx_nop_s && !branch_taken &&
                      (op_dx_s == OP_RTYPE) &&
                      ((alu_dx_s == ALU_MUL) || (alu_dx_s == ALU_DIV));

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    md_state_t        state_r;
    md_state_t        state_next_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [TO_W-1:0]  to_cnt_next_s;
    logic             md_timeout_r;
    logic             to_set_s;
    logic [CNT_W-1:0] stall_count_r;

    logic md_stall_s;
    logic ctrl_mult_s;
    logic ctrl_div_s;
    logic md_exc_s;

    // Next-state, watchdog and start-pulse decode for the mult/div sequencer.
    always_comb begin
        state_next_s  = state_r;
        to_cnt_next_s = to_cnt_r;
        md_stall_s    = 1'b0;
        ctrl_mult_s   = 1'b0;
        ctrl_div_s    = 1'b0;
        md_exc_s      = 1'b0;
        to_set_s      = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (md_hit_s) begin
                    // Start pulse is combinational: the unit latches operands
                    // from the D/X read ports in this very cycle.
                    if (is_mul_s) begin
                        ctrl_mult_s = 1'b1;
                    end else begin
                        ctrl_div_s  = 1'b1;
                    end
                    to_cnt_next_s = {TO_W{1'b0}};
                    md_stall_s    = 1'b1;
                    state_next_s  = MD_BUSY;
                end else begin
                    state_next_s  = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (data_resultRDY) begin
                    // Release cycle: the mul/div moves into X/M with its result,
                    // so the next IDLE cycle sees a different ir_dx.
                    md_exc_s     = data_exception;
                    state_next_s = MD_IDLE;
                end else if (to_cnt_r == TO_LAST) begin
                    to_set_s     = 1'b1;
                    state_next_s = MD_IDLE;
                end else begin
                    to_cnt_next_s = to_cnt_r + TO_ONE;
                    md_stall_s    = 1'b1;
                    state_next_s  = MD_BUSY;
                end
            end
            default: begin
                state_next_s  = MD_IDLE;
                to_cnt_next_s = {TO_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and watchdog counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= MD_IDLE;
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            to_cnt_r <= to_cnt_next_s;
        end
    end

    // Sticky watchdog-abort flag; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_timeout_r <= 1'b0;
        end else if (to_set_s) begin
            md_timeout_r <= 1'b1;
        end else begin
            md_timeout_r <= md_timeout_r;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control. A taken branch squashes the very instruction that
    // would otherwise be stalled, so flush takes priority over load-use.
    // ------------------------------------------------------------------
    assign hold_fd   = (md_stall_s | lu_s) & ~branch_taken;
    assign hold_dx   = md_stall_s;
    assign bubble_dx = lu_s & ~md_stall_s & ~branch_taken;
    assign flush_fd  = branch_taken;
    assign flush_dx  = branch_taken;
    assign ctrl_MULT = ctrl_mult_s;
    assign ctrl_DIV  = ctrl_div_s;
    assign md_exc    = md_exc_s;
    assign md_busy   = (state_r == MD_BUSY);
    assign md_timeout = md_timeout_r;

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (hold_fd && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Produces the stall, bubble and flush controls that the forwarding (bypass) control cannot handle, and sequences the multi-cycle mult/div unit.
- Sits in the decode/execute boundary of the 5-stage pipeline.
- Consumes ir_fd, ir_dx and the X-stage branch resolution.
- Drives hold enables for PC, F/D and D/X, nop insertion into D/X and F/D, and ctrl_MULT/ctrl_DIV start pulses.

Parameters:
MD_TIMEOUT, 40, cycles in MD_BUSY without data_resultRDY before forced abort
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clock  input  1  pipeline clock
reset  input  1  asynchronous, active-low reset
ir_fd  input  32  instruction in F/D latch
ir_dx  input  32  instruction in D/X latch
branch_taken  input  1  X stage resolved a taken branch/jump (bne, blt, j, jal, jr, bex)
data_resultRDY  input  1  multdiv result valid this cycle
data_exception  input  1  multdiv exception, qualified by data_resultRDY
hold_fd  output  1  hold PC and F/D latch
hold_dx  output  1  hold D/X latch
bubble_dx  output  1  load nop into D/X
flush_fd  output  1  load nop into F/D
flush_dx  output  1  load nop into D/X
ctrl_MULT  output  1  one-cycle multiply start
ctrl_DIV  output  1  one-cycle divide start
md_busy  output  1  FSM in MD_BUSY
md_exc  output  1  one-cycle pulse: result returned with data_exception
md_timeout  output  1  sticky: abort by timeout; cleared only by reset
stall_count  output  CNT_W  saturating count of cycles with hold_fd=1

Behaviour:
Decode:
- Opcode is [31:27]; rd is [26:22]; rs is [21:17]; rt is [16:12].
- The R-type ALU op is [6:2]: mul=00110, div=00111.
- An all-zero instruction is a nop and never causes a hazard.

Load-use detection (combinational):
- lu = ir_dx opcode 01000 (lw) with rd_dx != 0.
- ir_fd must be a non-nop that reads a source register equal to rd_dx.
- Source sets for ir_fd:
  - R-type: {rs, rt}.
  - addi/lw: {rs}.
  - bne/blt: {rd, rs}.
  - jr: {rd}.
  - sw: {rs} only. The sw data register (rd) is excluded because store-data forwarding covers it.
  - j, jal, bex, setx: none.

Mult/div FSM, states MD_IDLE, MD_BUSY:
- md_hit = ir_dx is R-type mul/div, non-nop, and branch_taken=0.
- MD_IDLE:
  - If md_hit: pulse ctrl_MULT or ctrl_DIV (combinational, this cycle only), clear the timeout counter, and go to MD_BUSY.
  - Otherwise stay in MD_IDLE.
- MD_BUSY:
  - If data_resultRDY: go to MD_IDLE; md_exc = data_exception this cycle.
  - Else if the counter equals MD_TIMEOUT-1: go to MD_IDLE and set md_timeout.
  - Else increment the counter.
- md_stall = (MD_IDLE & md_hit) | (MD_BUSY & ~data_resultRDY & ~timeout_hit).
  - The release cycle lets the mul/div advance into X/M with its result.
  - The next cycle in MD_IDLE sees a new ir_dx, so there is no re-trigger.

Outputs:
- hold_fd = (md_stall | lu) & ~branch_taken.
- hold_dx = md_stall.
- bubble_dx = lu & ~md_stall & ~branch_taken.
- flush_fd = flush_dx = branch_taken.
- Flush beats load-use stall: the stalled instruction is being squashed.
- branch_taken cannot coincide with MD_BUSY, since X/M then holds the mul/div. If it does, flush outputs still assert and the FSM is unaffected.

stall_count:
- Increments on every clock edge where hold_fd=1.
- Saturates at all-ones.

Reset (asynchronous, active-low):
- FSM to MD_IDLE; timeout counter, md_timeout and stall_count to 0.
- Registered outputs are 0. Combinational outputs follow inputs.
- Reset asserted mid MD_BUSY aborts immediately. No ctrl_MULT/ctrl_DIV is issued until a new md_hit after reset release.

Test Plan:
- lw r3 in DX, add r5,r3,r4 in FD -> one cycle with hold_fd=1, bubble_dx=1; next cycle both 0; stall_count=1.
- lw r3 in DX, sw r3,0(r7) in FD -> no stall. With sw r7,0(r3) in FD -> one-cycle stall. lw r0 in DX -> never stalls.
- mul in DX, data_resultRDY after 17 busy cycles:
  - Issue cycle: ctrl_MULT=1, hold_fd=hold_dx=1.
  - md_busy=1 for 17 cycles.
  - RDY cycle: hold_dx=0.
  - Back-to-back div next cycle: ctrl_DIV pulses once.
- div in DX, data_resultRDY never arrives -> after MD_TIMEOUT (40) busy cycles FSM returns to MD_IDLE, md_timeout=1 and stays 1, stalls release.
- Load-use hazard and branch_taken=1 in the same cycle -> flush_fd=flush_dx=1, hold_fd=0, bubble_dx=0. mul in DX with branch_taken=1 -> no ctrl_MULT.
- Reset asserted while in MD_BUSY -> outputs drop immediately; after release, md_busy=0, stall_count=0. data_resultRDY with data_exception -> md_exc pulses for exactly one cycle.
